// File: rtl/morse_encoder.sv
// Morse letter keyer: plays a dot/dash pattern on led, with letter-gap timing,
// optional auto-repeat, abort, and rejection of out-of-range lengths.
module morse_encoder #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int MAX_LEN     = 4,
    parameter int DASH_UNITS  = 3,
    parameter int GAP_UNITS   = 1,
    parameter int END_UNITS   = 3,
    localparam int LW         = $clog2(MAX_LEN + 1)
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LW-1:0]      length,
    input  logic               rpt,
    input  logic               abort,
    output logic               led,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int MAX_DE    = (DASH_UNITS > END_UNITS) ? DASH_UNITS : END_UNITS;
    localparam int MAX_UNITS = (MAX_DE > GAP_UNITS) ? MAX_DE : GAP_UNITS;
    localparam int MAX_DUR   = MAX_UNITS * UNIT_CYCLES;
    localparam int CW        = $clog2(MAX_DUR);

    // Terminal count of each phase; the counter runs 0 .. duration-1.
    localparam logic [CW-1:0] DOT_LAST  = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] DASH_LAST = CW'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CW-1:0] END_LAST  = CW'(END_UNITS * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MARK   = 2'd1,
        S_SPACE  = 2'd2,
        S_ENDGAP = 2'd3
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      rem_q;
    logic [MAX_LEN-1:0] lat_pat_q;
    logic [LW-1:0]      lat_len_q;
    logic               led_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               phase_last_s;
    logic               len_ok_s;

    assign len_ok_s = (length != {LW{1'b0}}) && (length <= LW'(MAX_LEN));

    // Flags the final cycle of the current timed phase.
    always_comb begin
        phase_last_s = 1'b0;
        case (state_q)
            S_MARK: begin
                if (pat_q[MAX_LEN-1]) begin
                    phase_last_s = (cnt_q == DASH_LAST);
                end else begin
                    phase_last_s = (cnt_q == DOT_LAST);
                end
            end
            S_SPACE:  phase_last_s = (cnt_q == GAP_LAST);
            S_ENDGAP: phase_last_s = (cnt_q == END_LAST);
            default:  phase_last_s = 1'b0;
        endcase
    end

    // Keyer state machine with registered outputs.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            pat_q     <= {MAX_LEN{1'b0}};
            rem_q     <= {LW{1'b0}};
            lat_pat_q <= {MAX_LEN{1'b0}};
            lat_len_q <= {LW{1'b0}};
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= {CW{1'b0}};
                    // abort has priority over start: nothing is latched and no err
                    if (start && !abort) begin
                        if (len_ok_s) begin
                            pat_q     <= pattern;
                            rem_q     <= length;
                            lat_pat_q <= pattern;
                            lat_len_q <= length;
                            state_q   <= S_MARK;
                            led_q     <= 1'b1;
                            busy_q    <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        cnt_q   <= {CW{1'b0}};
                        led_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!phase_last_s) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= {CW{1'b0}};
                        case (state_q)
                            S_MARK: begin
                                led_q <= 1'b0;
                                if (rem_q > LW'(1)) begin
                                    state_q <= S_SPACE;
                                end else begin
                                    state_q <= S_ENDGAP;
                                end
                            end
                            S_SPACE: begin
                                pat_q   <= pat_q << 1;
                                rem_q   <= rem_q - LW'(1);
                                state_q <= S_MARK;
                                led_q   <= 1'b1;
                            end
                            S_ENDGAP: begin
                                done_q <= 1'b1;
                                if (rpt) begin
                                    pat_q   <= lat_pat_q;
                                    rem_q   <= lat_len_q;
                                    state_q <= S_MARK;
                                    led_q   <= 1'b1;
                                end else begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                                led_q   <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_morse_encoder.sv
// Scoreboard bench for morse_encoder: a waveform-list reference model predicts
// {led,busy,done,err} for every clock edge; a forked monitor compares each cycle.
module tb_morse_encoder;

    localparam int U    = 4;
    localparam int DASH = 3;
    localparam int GAP  = 1;
    localparam int ENDG = 3;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [2:0] length;
    logic       rpt;
    logic       abort;
    logic       led;
    logic       busy;
    logic       done;
    logic       err;

    morse_encoder #(
        .UNIT_CYCLES(U),
        .MAX_LEN    (4),
        .DASH_UNITS (DASH),
        .GAP_UNITS  (GAP),
        .END_UNITS  (ENDG)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .start   (start),
        .pattern (pattern),
        .length  (length),
        .rpt     (rpt),
        .abort   (abort),
        .led     (led),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: a letter is the list of led levels, one entry per busy cycle.
    bit         wave_q[$];
    bit         sending = 1'b0;
    logic [3:0] lat_pat;
    int         lat_len;

    task automatic load_wave(input logic [3:0] pat, input int len);
        wave_q.delete();
        for (int i = 0; i < len; i++) begin
            int mark_len;
            int space_len;
            mark_len  = pat[3-i] ? DASH * U : U;
            space_len = (i == len - 1) ? ENDG * U : GAP * U;
            repeat (mark_len) wave_q.push_back(1'b1);
            repeat (space_len) wave_q.push_back(1'b0);
        end
    endtask

    task automatic model_edge(input bit st, input bit ab, input bit rp,
                              input logic [3:0] pat, input logic [2:0] len,
                              output logic [3:0] v);
        bit b;
        v = 4'b0000;
        if (!sending) begin
            if (st && !ab) begin
                if (len >= 3'd1 && len <= 3'd4) begin
                    lat_pat = pat;
                    lat_len = int'(len);
                    load_wave(lat_pat, lat_len);
                    sending = 1'b1;
                    b = wave_q.pop_front();
                    v = {b, 1'b1, 1'b0, 1'b0};
                end else begin
                    v = 4'b0001;
                end
            end
        end else if (ab) begin
            sending = 1'b0;
            wave_q.delete();
        end else if (wave_q.size() > 0) begin
            b = wave_q.pop_front();
            v = {b, 1'b1, 1'b0, 1'b0};
        end else if (rp) begin
            load_wave(lat_pat, lat_len);
            b = wave_q.pop_front();
            v = {b, 1'b1, 1'b1, 1'b0};
        end else begin
            sending = 1'b0;
            v = 4'b0010;
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit rp,
                        input logic [3:0] pat, input logic [2:0] len);
        exp_t e;
        start   = st;
        abort   = ab;
        rpt     = rp;
        pattern = pat;
        length  = len;
        e.cyc   = cyc_cnt + 1;
        model_edge(st, ab, rp, pat, len, e.v);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rp);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rp, 4'b0000, 3'd0);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({led, busy, done, err} !== 4'b0000) begin
            fails++;
            $display("FAIL %s: got led/busy/done/err=%b want 0000", name, {led, busy, done, err});
        end
    endtask

    // Asserts reset between edges, checks the outputs clear with no clock edge.
    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        sending = 1'b0;
        wave_q.delete();
        repeat (hold) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        rpt     = 1'b0;
        pattern = 4'b0000;
        length  = 3'd0;

        fork
            begin : monitor
                int shown;
                shown = 0;
                forever begin
                    @(negedge clk);
                    if (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
                        exp_t s;
                        s = exp_q.pop_front();
                        tests++;
                        fails++;
                        $display("FAIL stale_expect: cycle %0d never checked (now %0d)", s.cyc, cyc_cnt);
                    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
                        exp_t e;
                        e = exp_q.pop_front();
                        tests++;
                        if ({led, busy, done, err} !== e.v) begin
                            fails++;
                            if (shown < 30) begin
                                shown++;
                                $display("FAIL outputs cycle %0d: got led/busy/done/err=%b want %b",
                                         cyc_cnt, {led, busy, done, err}, e.v);
                            end
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check_zero("in_reset");
        reset = 1'b1;
        idle(2, 1'b0);

        // dot then dash
        step(1'b1, 1'b0, 1'b0, 4'b0100, 3'd2);
        idle(36, 1'b0);

        // rejected lengths
        step(1'b1, 1'b0, 1'b0, 4'b1111, 3'd0);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b1010, 3'd5);
        idle(2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0011, 3'd7);
        idle(2, 1'b0);

        // repeat mode, then release repeat
        step(1'b1, 1'b0, 1'b1, 4'b0000, 3'd1);
        idle(50, 1'b1);
        idle(25, 1'b0);

        // abort mid-letter, then a normal letter
        step(1'b1, 1'b0, 1'b0, 4'b1010, 3'd4);
        idle(9, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'b0000, 3'd0);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b1110, 3'd3);
        idle(70, 1'b0);

        // start while busy, and start+abort in idle
        step(1'b1, 1'b0, 1'b0, 4'b1000, 3'd2);
        idle(5, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b1111, 3'd4);
        idle(6, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b0000, 3'd0);
        idle(40, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'b1100, 3'd2);
        step(1'b1, 1'b1, 1'b0, 4'b1100, 3'd0);
        idle(3, 1'b0);

        // reset during a dash, then a full fresh letter
        step(1'b1, 1'b0, 1'b0, 4'b1000, 3'd1);
        idle(6, 1'b0);
        do_reset(3);
        idle(3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 4'b1000, 3'd1);
        idle(30, 1'b0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (n % 997 == 500) begin
                do_reset($urandom_range(1, 3));
            end
            step($urandom_range(0, 9) == 0, $urandom_range(0, 79) == 0,
                 $urandom_range(0, 3) == 0, 4'($urandom), 3'($urandom_range(0, 7)));
        end
        idle(3, 1'b0);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
